// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB definitions used by the command initiator and the
//               PWM register responders: transfer state encoding and default
//               address/data widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Transfer phase of the initiator.
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master
// Description : Single-outstanding APB initiator. Converts a valid/ready
//               command stream into APB SETUP/ACCESS transfers and returns
//               read data / error status on a valid/ready response channel.
//               A bounded wait-state timeout aborts transfers to a stuck
//               completer.
// Ports       : PCLK, PRESETn            - clock, async active-low reset
//               cmd_valid/ready/write/addr/wdata - command channel
//               rsp_valid/ready/rdata/err/timeout - response channel
//               PSEL/PENABLE/PWRITE/PADDR/PWDATA  - APB request
//               PREADY/PSLVERR/PRDATA             - APB completion
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit when the
  // timeout is disabled so the declaration stays legal.
  localparam int              c_CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;

  apb_state_e          state_q, state_d;
  logic [c_CNT_W-1:0]  cnt_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                tmo_q;

  logic                w_tmo_hit;

  assign w_tmo_hit = (TIMEOUT != 0) && (cnt_q == c_CNT_LIMIT);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. PREADY is checked before the timeout so a completer
  // answering on the limit cycle still completes normally.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE:   if (cmd_valid)             state_d = APB_SETUP;
      APB_SETUP:                             state_d = APB_ACCESS;
      APB_ACCESS: if (PREADY || w_tmo_hit)   state_d = APB_RESP;
      APB_RESP:   if (rsp_ready)             state_d = APB_IDLE;
      default:                               state_d = APB_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      APB_IDLE:   cmd_ready = 1'b1;
      APB_SETUP:  PSEL      = 1'b1;
      APB_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      APB_RESP:   rsp_valid = 1'b1;
      default:    cmd_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request/response datapath and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      case (state_q)
        APB_IDLE: begin
          // Request fields only change on acceptance, so they stay stable
          // through SETUP and ACCESS and hold their last value while idle.
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            cnt_q    <= '0;
          end
        end
        APB_ACCESS: begin
          if (PREADY) begin
            rdata_q <= pwrite_q ? '0 : PRDATA;
            err_q   <= PSLVERR;
            tmo_q   <= 1'b0;
          end else if (w_tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Scoreboard bench for apb_cmd_master. A driver issues
//               commands and pushes predicted responses; an APB completer
//               model serves each transfer; a monitor compares every
//               response handshake against the scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

  localparam int TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        slverr;
    int          waits;   // PREADY-low ACCESS cycles before PREADY rises
  } xact_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  xact_t       slv_q[$];
  rsp_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          rr_mode = 1;  // 0: rsp_ready low, 1: high, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a stuck completer (no PREADY within TMO ACCESS cycles) yields a
  // timeout; otherwise the completer's answer passes through, reads only.
  function automatic rsp_t predict(input xact_t x);
    rsp_t r;
    if (x.waits >= TMO) begin
      r.rdata = 32'h0; r.err = 1'b1; r.tmo = 1'b1;
    end else begin
      r.rdata = x.write ? 32'h0 : x.rdata; r.err = x.slverr; r.tmo = 1'b0;
    end
    return r;
  endfunction

  // ---------------- APB completer model ----------------
  initial begin
    xact_t cur;
    int    k;
    bit    have;
    have = 0; k = 0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        have = 0; PREADY = 1'b0;
      end else if (PSEL && !PENABLE) begin
        if (slv_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL apb_unexpected_setup: got addr %0h expected no transfer", PADDR);
          have = 0;
        end else begin
          cur = slv_q.pop_front(); have = 1; k = 0;
          chk("setup_paddr", PADDR, cur.addr);
          chk("setup_pwrite", PWRITE, cur.write);
          if (cur.write) chk("setup_pwdata", PWDATA, cur.wdata);
        end
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end else if (PSEL && PENABLE && have) begin
        k++;
        chk("access_paddr", PADDR, cur.addr);
        chk("access_pwrite", PWRITE, cur.write);
        if (cur.write) chk("access_pwdata", PWDATA, cur.wdata);
        if (k > cur.waits) begin
          PREADY = 1'b1; PRDATA = cur.rdata; PSLVERR = cur.slverr;
          if (cur.write) mem[PADDR] = PWDATA;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
      end else begin
        // Outside ACCESS the initiator must ignore these.
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
    end
  end

  // ---------------- response ready driver ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      case (rr_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t        e;
    bit          held;
    logic [31:0] h_rdata;
    logic        h_err, h_tmo;
    held = 0; h_rdata = '0; h_err = 1'b0; h_tmo = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        held = 0;
      end else if (rsp_valid) begin
        if (held) begin
          chk("rsp_stable_rdata", rsp_rdata, h_rdata);
          chk("rsp_stable_err", rsp_err, h_err);
          chk("rsp_stable_tmo", rsp_timeout, h_tmo);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected: got rdata %0h expected no response", rsp_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.tmo);
          end
          held = 0;
        end else begin
          held = 1; h_rdata = rsp_rdata; h_err = rsp_err; h_tmo = rsp_timeout;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic push_cmd(input xact_t x);
    cmd_valid = 1'b1; cmd_write = x.write; cmd_addr = x.addr; cmd_wdata = x.wdata;
    slv_q.push_back(x);
    exp_q.push_back(predict(x));
  endtask

  task automatic drop_cmd();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  // Returns #1 after the accepting clock edge.
  task automatic send(input xact_t x);
    bit ok;
    ok = 0;
    @(posedge PCLK); #1;
    push_cmd(x);
    for (int n = 0; n < 300; n++) begin
      @(negedge PCLK);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL cmd_accept: got cmd_ready 0 for 300 cycles expected 1");
      void'(slv_q.pop_back()); void'(exp_q.pop_back());
    end
    @(posedge PCLK); #1;
    drop_cmd();
  endtask

  task automatic count_access(output int n);
    bit ok;
    n = 0; ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge PCLK);
      if (rsp_valid) begin ok = 1; break; end
      if (PSEL && PENABLE) n++;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL rsp_wait: got no rsp_valid in 200 cycles expected one");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge PCLK);
    chk("drain_scoreboard_empty", exp_q.size(), 0);
  endtask

  function automatic xact_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input logic se, input int wt);
    xact_t x;
    x.write = w; x.addr = a; x.wdata = wd; x.rdata = rd; x.slverr = se; x.waits = wt;
    return x;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    xact_t x;
    drop_cmd();
    cmd_valid = 1'b0;
    #12;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_psel", PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_rsp_err", rsp_err, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Zero-wait write, cycle-exact phases.
    send(mk(1'b1, 32'h000, 32'h1, 32'h0, 1'b0, 0));
    @(negedge PCLK);
    chk("zw_setup_psel", PSEL, 1); chk("zw_setup_penable", PENABLE, 0);
    chk("zw_setup_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("zw_access_psel", PSEL, 1); chk("zw_access_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("zw_rsp_valid", rsp_valid, 1); chk("zw_rsp_psel", PSEL, 0);
    chk("zw_rsp_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("zw_next_cmd_ready", cmd_ready, 1);
    chk("zw_reg_written", mem.exists(32'h0) ? mem[32'h0] : 32'hDEAD_BEEF, 32'h1);

    // Read with 3 wait states: PREADY rises on the counter's limit cycle.
    send(mk(1'b0, 32'h004, 32'h0, 32'hA5A5_0001, 1'b0, 3));
    count_access(n);
    chk("wait3_access_cycles", n, 4);

    // Slave error.
    send(mk(1'b0, 32'h008, 32'h0, 32'h1234_5678, 1'b1, 1));
    count_access(n);
    chk("slverr_access_cycles", n, 2);

    // Stuck completer -> timeout.
    send(mk(1'b1, 32'h00C, 32'hCAFE_0000, 32'h0, 1'b0, 100));
    count_access(n);
    chk("tmo_access_cycles", n, TMO);
    chk("tmo_psel_low", PSEL, 0);

    // Response back-pressure.
    drain();
    rr_mode = 0;
    send(mk(1'b0, 32'h010, 32'h0, 32'h0BAD_F00D, 1'b0, 0));
    count_access(n);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rr_mode = 1;
    @(posedge PCLK); #1;
    push_cmd(mk(1'b1, 32'h014, 32'h5555_AAAA, 32'h0, 1'b0, 0));
    @(negedge PCLK);
    chk("bp_release_cmd_ready", cmd_ready, 0);
    chk("bp_release_rsp_valid", rsp_valid, 1);
    @(negedge PCLK);
    chk("bp_cmd_after_release", cmd_ready, 1);
    @(posedge PCLK); #1;
    drop_cmd();
    drain();

    // Reset during ACCESS.
    send(mk(1'b1, 32'h018, 32'h7777_0000, 32'h0, 1'b0, 100));
    @(posedge PCLK);           // enters ACCESS
    #3 PRESETn = 1'b0;
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    slv_q.delete();
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end

    // Randomized traffic.
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      x.write  = 1'($urandom);
      x.addr   = $urandom & 32'h0000_0FFC;
      x.wdata  = $urandom;
      x.rdata  = $urandom;
      x.slverr = ($urandom_range(0, 3) == 0);
      x.waits  = ($urandom_range(0, 7) == 0) ? 50 : int'($urandom_range(0, 5));
      send(x);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB initiator that turns a valid/ready command stream from the control core into APB SETUP/ACCESS transfers toward the PWM peripheral registers on the PCLK domain. It returns read data and error status on a valid/ready response channel. A bounded wait-state timeout keeps a stuck slave from hanging the core. It is the requester end of the bus whose responders are the PWM control register blocks.

## Interface
- ADDR_W, 32, width of cmd_addr/PADDR
- DATA_W, 32, width of write/read data
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort; 0 disables timeout
- PCLK  in  1  APB clock, sole clock
- PRESETn  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and on timeout)
- rsp_err  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  response ended by timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W, PWDATA  out  DATA_W  APB address/data
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_W  APB completer signals

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. Handshake latches write/addr/wdata into PWRITE/PADDR/PWDATA -> SETUP.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR -> RESP.
  - PREADY=0: increment wait counter. Counter reaching TIMEOUT-1 (TIMEOUT≠0): rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> RESP.
- RESP: PSEL=PENABLE=0, rsp_valid=1 holding stable until rsp_ready; on handshake -> IDLE.
- PADDR/PWDATA/PWRITE hold stable from SETUP through end of ACCESS and keep last value while idle. Completers that sample in SETUP and completers that sample in ACCESS both see valid data.
- Wait counter width = clog2(TIMEOUT+1), cleared on entry to SETUP; no wrap (saturates at abort).
- PSLVERR and PRDATA ignored unless PREADY=1 in ACCESS.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. FSM=IDLE, counter=0.
- Reset mid-transfer aborts immediately; no response produced for the aborted command.
- Zero-wait transfer: cmd handshake cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3. Earliest next cmd handshake N+4 if rsp_ready held 1.
- Each PREADY=0 cycle in ACCESS adds one cycle. Timeout aborts after TIMEOUT ACCESS cycles; rsp_valid follows the next cycle.
- cmd_ready is 0 in SETUP/ACCESS/RESP; at most one transfer outstanding.
- PREADY=1 on the same cycle the counter hits its limit: normal completion wins, rsp_timeout=0.

## Structure
- Shared package apb_pkg: state enum (IDLE/SETUP/ACCESS/RESP) and default ADDR_W/DATA_W constants, shared with the APB responders.
- Single module; the wait/timeout counter stays inline (no sub-module).

## Test plan
- Write addr 0x000, data 0x1, PREADY=1 -> PSEL rises N+1, PENABLE N+2; responder PWM enable register reads 1; rsp_err=0 at N+3.
- Read 0x004 with PREADY low 3 cycles, PRDATA=0xA5A5_0001 -> ACCESS lasts 4 cycles; rsp_rdata=0xA5A5_0001.
- PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0.
- TIMEOUT=4, PREADY stuck 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL low.
- rsp_ready held 0 for 5 cycles -> rsp_valid/data stable, cmd_ready=0 throughout; cmd accepted the cycle after release.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE/rsp_valid 0 asynchronously, cmd_ready=1 after release, no stale response.
